pipe_out_block_arbiter: RTL and testbench
=========================================

Name: pipe_out_block_arbiter

Overview:
- Shares one block-throttled PipeOut endpoint (16-bit, host-paced by `ep_read`/`ep_ready`) between N_SRC on-chip data sources, one complete block at a time.
- Arbitration is round-robin among enabled sources that have a full block buffered.
- The block drives the endpoint's ready flag, steers each read strobe to the granted source, and muxes that source's data back.
- Sits between the per-source FIFOs and the PipeOut endpoint, in the `ti_clk` domain. Control comes from a WireIn mask; status goes to a WireOut.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- SEL_W, 2, width of the source index; must equal ceil(log2(N_SRC)).
- BLOCK_WORDS, 256, 16-bit words per pipe block (2..1024).

Ports:
- clk  in  1  endpoint clock (`ti_clk`); all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable_mask  in  N_SRC  per-source enable (WireIn bits).
- src_block_avail  in  N_SRC  source i holds at least BLOCK_WORDS words.
- src_read  out  N_SRC  read strobe to source i; its data is valid on the following cycle.
- src_data  in  16*N_SRC  source i data on bits [16*i +: 16].
- pipe_out_read  in  1  `ep_read` from the PipeOut endpoint.
- pipe_out_ready  out  1  `ep_ready` to the PipeOut endpoint.
- pipe_out_data  out  16  `ep_datain` to the PipeOut endpoint.
- active_src  out  SEL_W  index of the current or last granted source.
- busy  out  1  a grant is outstanding (READY, XFER or DONE).
- blocks_served  out  16  count of completed blocks, wraps at 0xFFFF to 0.
- protocol_err  out  1  sticky: a read arrived while no block was granted.

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer last_grant = N_SRC-1, so source 0 has first priority; word counter 0.
- Request vector: req = enable_mask & src_block_avail.
- IDLE:
  - If req is nonzero, go to ARB next cycle.
- ARB (exactly 1 cycle):
  - Select the first set bit of req searching (last_grant+1) mod N_SRC upward, with wrap.
  - Register it into sel and active_src; go to READY.
  - If req has become 0, return to IDLE.
- READY:
  - pipe_out_ready = 1.
  - If req[sel] drops before the first read (mask cleared or avail withdrawn): clear ready the next cycle, return to IDLE, leave last_grant unchanged.
  - On the first pipe_out_read: go to XFER with count = 1.
- XFER:
  - pipe_out_ready = 0.
  - Each pipe_out_read increments count. In the same cycle, src_read[sel] = pipe_out_read (combinational); all other src_read bits stay 0.
  - When count reaches BLOCK_WORDS on a read, go to DONE.
  - enable_mask and src_block_avail are ignored in XFER; a started block always completes.
- READY read steering: src_read[sel] is also driven combinationally from pipe_out_read in READY, so the first word is fetched on the read that triggers READY->XFER.
- Data mux:
  - pipe_out_data = src_data[sel] whenever state is READY, XFER or DONE; otherwise 16'h0000.
  - sel is held through DONE, so the last word (valid the cycle after the final read) is delivered.
- DONE (1 cycle):
  - last_grant <= sel; blocks_served += 1; go to IDLE.
  - Minimum gap between the final read and the next ready assertion is 3 cycles (DONE, IDLE, ARB).
- Stray reads:
  - A pipe_out_read in IDLE, ARB or DONE sets protocol_err.
  - A read in XFER beyond BLOCK_WORDS cannot occur, because the state has already left XFER.
  - Stray reads are not forwarded.
  - protocol_err clears only on reset.
- busy = 1 in READY, XFER and DONE.
- Reset mid-block: the next cycle is IDLE with all src_read 0 and ready 0. The partially read source is not re-synchronised; its FIFO reset is the user's responsibility.
- Fairness: a source that is continuously requesting waits at most N_SRC-1 blocks.

Test Plan:
1. Single source: N_SRC=4, BLOCK_WORDS=8, mask=0001, avail[0]=1, source ramp 0..7.
   - ready rises 2 cycles after avail.
   - Host reads 8 words; host receives 0..7.
   - src_read[0] pulses 8 times; blocks_served=1.
   - ready is low for 3 cycles after the final read.
2. Round-robin: all four sources always available, mask=1111, 8 consecutive blocks.
   - Grant order is 0,1,2,3,0,1,2,3; active_src matches; blocks_served=8.
   - Every block's data carries its own source's tag.
3. Withdraw before first read: grant to source 2, then clear mask[2] while in READY.
   - Ready drops the next cycle; no src_read pulse occurs.
   - Next arbitration picks source 3 (last_grant unchanged at 1); blocks_served unchanged.
4. Mask change mid-block: clear mask[1] after 3 of 8 reads.
   - The remaining 5 reads are still steered to source 1 and the block completes.
   - Source 1 is not granted again while masked.
5. Stray read: pulse pipe_out_read in IDLE.
   - protocol_err=1 and stays set; src_read=0; pipe_out_data=0.
   - Normal transfers still succeed afterwards.
6. Reset mid-block: assert reset after 4 of 8 reads.
   - Next cycle: state IDLE, all outputs 0, blocks_served=0.
   - After reset, source 0 wins first arbitration.

Source files
------------

// File: rtl/pipe_out_block_arbiter.sv
// Round-robin arbiter sharing one block-throttled 16-bit PipeOut endpoint between
// N_SRC sources, granting one complete block at a time.
module pipe_out_block_arbiter #(
    parameter int N_SRC       = 4,
    parameter int SEL_W       = 2,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      enable_mask,
    input  logic [N_SRC-1:0]      src_block_avail,
    output logic [N_SRC-1:0]      src_read,
    input  logic [16*N_SRC-1:0]   src_data,
    input  logic                  pipe_out_read,
    output logic                  pipe_out_ready,
    output logic [15:0]           pipe_out_data,
    output logic [SEL_W-1:0]      active_src,
    output logic                  busy,
    output logic [15:0]           blocks_served,
    output logic                  protocol_err
);

    localparam int CNT_W = $clog2(BLOCK_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [SEL_W-1:0] LAST_SRC   = SEL_W'(N_SRC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READY,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       blocksServed_q, blocksServed_d;
    logic              protocolErr_q, protocolErr_d;

    logic [N_SRC-1:0]  req;
    logic [15:0]       srcWords [N_SRC];

    assign req = enable_mask & src_block_avail;

    for (genvar g = 0; g < N_SRC; g++) begin : g_words
        assign srcWords[g] = src_data[16*g +: 16];
    end

    // Search starts just past the last completed grant, so source 0 leads after reset.
    function automatic logic [SEL_W-1:0] rrPick(input logic [N_SRC-1:0] r,
                                                input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = int'(last) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = idx[SEL_W-1:0];
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sel_q          <= '0;
            lastGrant_q    <= LAST_SRC;
            count_q        <= '0;
            blocksServed_q <= '0;
            protocolErr_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            lastGrant_q    <= lastGrant_d;
            count_q        <= count_d;
            blocksServed_q <= blocksServed_d;
            protocolErr_q  <= protocolErr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        lastGrant_d    = lastGrant_q;
        count_d        = count_q;
        blocksServed_d = blocksServed_q;
        protocolErr_d  = protocolErr_q;
        src_read       = '0;
        pipe_out_ready = 1'b0;
        busy           = 1'b0;
        pipe_out_data  = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (pipe_out_read) protocolErr_d = 1'b1;
                if (req != '0) state_d = S_ARB;
            end
            S_ARB: begin
                if (pipe_out_read) protocolErr_d = 1'b1;
                if (req == '0) begin
                    state_d = S_IDLE;
                end else begin
                    sel_d   = rrPick(req, lastGrant_q);
                    state_d = S_READY;
                end
            end
            // A read in the same cycle as a withdrawal wins: that word is already gone.
            S_READY: begin
                pipe_out_ready  = 1'b1;
                busy            = 1'b1;
                pipe_out_data   = srcWords[sel_q];
                src_read[sel_q] = pipe_out_read;
                if (pipe_out_read) begin
                    count_d = CNT_W'(1);
                    state_d = S_XFER;
                end else if (!req[sel_q]) begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                busy            = 1'b1;
                pipe_out_data   = srcWords[sel_q];
                src_read[sel_q] = pipe_out_read;
                if (pipe_out_read) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_COUNT) state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy           = 1'b1;
                pipe_out_data  = srcWords[sel_q];
                if (pipe_out_read) protocolErr_d = 1'b1;
                lastGrant_d    = sel_q;
                blocksServed_d = blocksServed_q + 16'd1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign active_src    = sel_q;
    assign blocks_served = blocksServed_q;
    assign protocol_err  = protocolErr_q;

endmodule

// File: tb/tb_pipe_out_block_arbiter.sv
// Directed bench for pipe_out_block_arbiter: four tagged ramp sources behind an
// 8-word block endpoint, with a host that reads whole blocks back-to-back.
module tb_pipe_out_block_arbiter;

    localparam int N_SRC       = 4;
    localparam int SEL_W       = 2;
    localparam int BLOCK_WORDS = 8;

    logic                 clk;
    logic                 reset;
    logic [N_SRC-1:0]     enable_mask;
    logic [N_SRC-1:0]     src_block_avail;
    logic [N_SRC-1:0]     src_read;
    logic [16*N_SRC-1:0]  src_data;
    logic                 pipe_out_read;
    logic                 pipe_out_ready;
    logic [15:0]          pipe_out_data;
    logic [SEL_W-1:0]     active_src;
    logic                 busy;
    logic [15:0]          blocks_served;
    logic                 protocol_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] srcWord  [N_SRC];
    logic [11:0] srcPtr   [N_SRC];
    int          srcReads [N_SRC];

    pipe_out_block_arbiter #(
        .N_SRC      (N_SRC),
        .SEL_W      (SEL_W),
        .BLOCK_WORDS(BLOCK_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_mask    (enable_mask),
        .src_block_avail(src_block_avail),
        .src_read       (src_read),
        .src_data       (src_data),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_ready (pipe_out_ready),
        .pipe_out_data  (pipe_out_data),
        .active_src     (active_src),
        .busy           (busy),
        .blocks_served  (blocks_served),
        .protocol_err   (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each source presents {tag, ptr} the cycle after its read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (reset) begin
                srcPtr[i]   <= '0;
                srcWord[i]  <= '0;
                srcReads[i] <= 0;
            end else if (src_read[i]) begin
                srcWord[i]  <= {4'(i), srcPtr[i]};
                srcPtr[i]   <= srcPtr[i] + 12'd1;
                srcReads[i] <= srcReads[i] + 1;
            end
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign src_data[16*g +: 16] = srcWord[g];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_SRC-1:0] mask, input logic [N_SRC-1:0] avail);
        enable_mask     = mask;
        src_block_avail = avail;
    endtask

    task automatic resetDut();
        reset         = 1'b1;
        pipe_out_read = 1'b0;
        applyStimulus('0, '0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (!pipe_out_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(pipe_out_ready), 32'd1);
    endtask

    // Back-to-back host reads; each word arrives the cycle after its read.
    task automatic hostRead(input int n, input int src, input int firstPtr);
        for (int i = 0; i < n; i++) begin
            pipe_out_read = 1'b1;
            #1;
            checkOutput("src_read steer", 32'(src_read), 32'(1 << src));
            tick();
            checkOutput("host data", 32'(pipe_out_data), {16'h0, 4'(src), 12'(firstPtr + i)});
        end
        pipe_out_read = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        pipe_out_read   = 1'b0;
        enable_mask     = '0;
        src_block_avail = '0;

        $display("[TB] reset state");
        resetDut();
        checkOutput("reset ready", 32'(pipe_out_ready), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset src_read", 32'(src_read), 32'd0);
        checkOutput("reset data", 32'(pipe_out_data), 32'd0);
        checkOutput("reset active", 32'(active_src), 32'd0);
        checkOutput("reset blocks", 32'(blocks_served), 32'd0);
        checkOutput("reset perr", 32'(protocol_err), 32'd0);

        $display("[TB] single source");
        applyStimulus(4'b0001, 4'b0001);
        tick();
        checkOutput("t1 ready after 1", 32'(pipe_out_ready), 32'd0);
        tick();
        checkOutput("t1 ready after 2", 32'(pipe_out_ready), 32'd1);
        checkOutput("t1 busy", 32'(busy), 32'd1);
        checkOutput("t1 active", 32'(active_src), 32'd0);
        hostRead(BLOCK_WORDS, 0, 0);
        checkOutput("t1 gap1 ready", 32'(pipe_out_ready), 32'd0);
        tick();
        checkOutput("t1 gap2 ready", 32'(pipe_out_ready), 32'd0);
        checkOutput("t1 blocks", 32'(blocks_served), 32'd1);
        tick();
        checkOutput("t1 gap3 ready", 32'(pipe_out_ready), 32'd0);
        tick();
        checkOutput("t1 ready again", 32'(pipe_out_ready), 32'd1);
        checkOutput("t1 src0 reads", 32'(srcReads[0]), 32'd8);

        $display("[TB] round robin");
        resetDut();
        applyStimulus(4'b1111, 4'b1111);
        for (int b = 0; b < 8; b++) begin
            waitReady("t2 ready");
            checkOutput("t2 grant order", 32'(active_src), 32'(b % 4));
            hostRead(BLOCK_WORDS, b % 4, (b / 4) * 8);
        end
        tick();
        checkOutput("t2 blocks", 32'(blocks_served), 32'd8);

        $display("[TB] withdraw before first read");
        resetDut();
        applyStimulus(4'b0010, 4'b1111);
        waitReady("t3 ready src1");
        checkOutput("t3 first grant", 32'(active_src), 32'd1);
        hostRead(BLOCK_WORDS, 1, 0);
        applyStimulus(4'b0100, 4'b1111);
        waitReady("t3 ready src2");
        checkOutput("t3 grant src2", 32'(active_src), 32'd2);
        applyStimulus(4'b1011, 4'b1111);
        tick();
        checkOutput("t3 ready dropped", 32'(pipe_out_ready), 32'd0);
        checkOutput("t3 busy dropped", 32'(busy), 32'd0);
        checkOutput("t3 no src2 read", 32'(srcReads[2]), 32'd0);
        waitReady("t3 ready rearb");
        checkOutput("t3 rearb grant", 32'(active_src), 32'd3);
        checkOutput("t3 blocks", 32'(blocks_served), 32'd1);

        $display("[TB] mask change mid-block");
        resetDut();
        applyStimulus(4'b0010, 4'b1111);
        waitReady("t4 ready");
        checkOutput("t4 grant", 32'(active_src), 32'd1);
        hostRead(3, 1, 0);
        applyStimulus(4'b0001, 4'b1111);
        hostRead(5, 1, 3);
        waitReady("t4 ready next");
        checkOutput("t4 next grant", 32'(active_src), 32'd0);
        checkOutput("t4 src1 reads", 32'(srcReads[1]), 32'd8);
        checkOutput("t4 blocks", 32'(blocks_served), 32'd1);

        $display("[TB] stray read");
        resetDut();
        applyStimulus(4'b0000, 4'b1111);
        tick();
        pipe_out_read = 1'b1;
        #1;
        checkOutput("t5 stray src_read", 32'(src_read), 32'd0);
        checkOutput("t5 stray data", 32'(pipe_out_data), 32'd0);
        tick();
        pipe_out_read = 1'b0;
        checkOutput("t5 perr set", 32'(protocol_err), 32'd1);
        applyStimulus(4'b0001, 4'b1111);
        waitReady("t5 ready");
        hostRead(BLOCK_WORDS, 0, 0);
        tick();
        checkOutput("t5 blocks", 32'(blocks_served), 32'd1);
        checkOutput("t5 perr sticky", 32'(protocol_err), 32'd1);

        $display("[TB] reset mid-block");
        resetDut();
        applyStimulus(4'b1111, 4'b1111);
        waitReady("t6 ready src0");
        hostRead(BLOCK_WORDS, 0, 0);
        waitReady("t6 ready src1");
        checkOutput("t6 grant src1", 32'(active_src), 32'd1);
        hostRead(4, 1, 0);
        reset         = 1'b1;
        pipe_out_read = 1'b1;
        tick();
        checkOutput("t6 rst ready", 32'(pipe_out_ready), 32'd0);
        checkOutput("t6 rst busy", 32'(busy), 32'd0);
        checkOutput("t6 rst src_read", 32'(src_read), 32'd0);
        checkOutput("t6 rst data", 32'(pipe_out_data), 32'd0);
        checkOutput("t6 rst active", 32'(active_src), 32'd0);
        checkOutput("t6 rst blocks", 32'(blocks_served), 32'd0);
        pipe_out_read = 1'b0;
        reset         = 1'b0;
        waitReady("t6 ready after reset");
        checkOutput("t6 first grant", 32'(active_src), 32'd0);
        checkOutput("t6 perr clear", 32'(protocol_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
